// File: rtl/seq_mult_8_bit_pkg.sv
// Shared widths, iteration count and control-state encoding for the 8x8 sequential multiplier.
package seq_mult_8_bit_pkg;

    localparam int WIDTH  = 8;
    localparam int PROD_W = 2 * WIDTH;
    localparam int ITER   = WIDTH;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/rca_8_bit.sv
// 8-bit ripple-carry adder built from per-bit sum/carry equations.
// Purely combinational; no handshake, result follows inputs in the same cycle.
module rca_8_bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[8];

endmodule

// File: rtl/seq_mult_8_bit.sv
// Unsigned 8x8 shift-and-add multiplier around rca_8_bit; out_valid 9 cycles after the accept cycle.
// Takes operands only in IDLE; the product is held in DONE until out_ready, with no operand queueing.
module seq_mult_8_bit #(
    parameter int WIDTH = 8,
    parameter int ITER  = WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    import seq_mult_8_bit_pkg::*;

    if (WIDTH != 8 || ITER != 8) begin : g_bad_width
        $error("seq_mult_8_bit supports only WIDTH=8, ITER=8");
    end

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

    state_t             state, state_next;
    logic [WIDTH-1:0]   m_reg, acc_reg, q_reg;
    logic               c_reg;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [WIDTH-1:0]   acc_next;
    logic               c_next;

    rca_8_bit u_add (
        .a    (acc_reg),
        .b    (m_reg),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Add only when the current multiplier LSB is set; C is always zero between iterations.
    always_comb begin
        c_next   = c_reg;
        acc_next = acc_reg;
        if (q_reg[0]) begin
            c_next   = add_cout;
            acc_next = add_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)        state_next = RUN;
            RUN:     if (cnt == LAST_ITER) state_next = DONE;
            DONE:    if (out_ready)       state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg   <= '0;
            acc_reg <= '0;
            q_reg   <= '0;
            c_reg   <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m_reg   <= a;
                        q_reg   <= b;
                        acc_reg <= '0;
                        c_reg   <= 1'b0;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    acc_reg <= {c_next, acc_next[WIDTH-1:1]};
                    q_reg   <= {acc_next[0], q_reg[WIDTH-1:1]};
                    c_reg   <= 1'b0;
                    cnt     <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign product = {acc_reg, q_reg};

endmodule

// File: tb/tb_seq_mult_8_bit.sv
// Self-checking bench: directed vector table, hand-written corner sequences, random ops vs a*b.
module tb_seq_mult_8_bit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  a = 8'h00;
    logic [7:0]  b = 8'h00;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [15:0] product;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_mult_8_bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        logic [15:0] prod;
        int          hold;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full operation: handshake, latency, hold under backpressure, return to IDLE.
    task automatic run_op(input string name, input logic [7:0] va, input logic [7:0] vb,
                          input logic [15:0] exp, input int hold, input bit pulse);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({name, " in_ready"}, 32'(in_ready), 32'd1);
        out_ready = (hold == 0);
        a = va;
        b = vb;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        chk({name, " busy"}, 32'(busy), 32'd1);
        chk({name, " in_ready_run"}, 32'(in_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            if (pulse && lat == 3) begin
                a = 8'hFF;
                b = 8'hFF;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk({name, " latency"}, 32'(lat), 32'd9);
        chk({name, " product"}, 32'(product), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, " hold_valid"}, 32'(out_valid), 32'd1);
            chk({name, " hold_product"}, 32'(product), 32'(exp));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({name, " valid_drop"}, 32'(out_valid), 32'd0);
        chk({name, " idle_ready"}, 32'(in_ready), 32'd1);
        chk({name, " idle_product"}, 32'(product), 32'(exp));
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h0F, 8'h0F, 16'h00E1, 0};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01, 0};
        vecs[2] = '{8'h00, 8'hA5, 16'h0000, 0};
        vecs[3] = '{8'hA5, 8'h00, 16'h0000, 0};
        vecs[4] = '{8'h80, 8'h02, 16'h0100, 5};

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset product", 32'(product), 32'h0);
        chk("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset in_ready", 32'(in_ready), 32'd1);
        chk("post_reset busy", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].prod, vecs[i].hold, 1'b0);
        end

        run_op("ignore_in_run", 8'h12, 8'h34, 16'h03A8, 0, 1'b1);

        // Abort an operation mid-RUN with asynchronous reset.
        out_ready = 1'b1;
        a = 8'hC3;
        b = 8'h5A;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort product", 32'(product), 32'h0);
        chk("abort busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort in_ready", 32'(in_ready), 32'd1);
        run_op("after_abort", 8'h03, 8'h07, 16'h0015, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [7:0]  ra;
            logic [7:0]  rb;
            logic [15:0] model;
            ra = 8'($urandom);
            rb = 8'($urandom);
            model = 16'(ra) * 16'(rb);
            run_op($sformatf("rand%0d", n), ra, rb, model, int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
